// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller.
//   trap_state_t : FSM states of the trap sequencer
//   IRQ_* / EXC_*: architectural cause codes referenced by the design
//   MSTATUS_MIE  : bit position of the global machine interrupt enable
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ENTER,
        REDIRECT,
        RET
    } trap_state_t;

    localparam logic [3:0] IRQ_MSI     = 4'd3;
    localparam logic [3:0] IRQ_MTI     = 4'd7;
    localparam logic [3:0] IRQ_MEI     = 4'd11;
    localparam logic [3:0] EXC_ECALL_M = 4'd11;
    localparam logic [3:0] EXC_ILLEGAL = 4'd2;

    localparam int MSTATUS_MIE = 3;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority interrupt selector.
//   mask_i  : pending & enabled interrupt lines, bit i = cause i
//   valid_o : at least one line set
//   cause_o : winning cause; 11 > 3 > 7, then remaining bits lowest index first
module irq_priority_encoder
    import trap_pkg::*;
(
    input  logic [15:0] mask_i,
    output logic        valid_o,
    output logic [3:0]  cause_o
);

    always_comb begin
        valid_o = |mask_i;
        cause_o = 4'd0;
        // Descending scan so the lowest ordinary index is the last to win.
        for (int i = 15; i >= 0; i--) begin
            if (mask_i[i] && (4'(i) != IRQ_MSI) && (4'(i) != IRQ_MTI) && (4'(i) != IRQ_MEI))
                cause_o = 4'(i);
        end
        // The three standard machine interrupts override in reverse priority order.
        if (mask_i[IRQ_MTI]) cause_o = IRQ_MTI;
        if (mask_i[IRQ_MSI]) cause_o = IRQ_MSI;
        if (mask_i[IRQ_MEI]) cause_o = IRQ_MEI;
    end

endmodule

// File: rtl/trap_controller.sv
// Trap entry / MRET sequencer for the in-order core.
// Inputs : exception report (excValid/excCode/excPc/excTval), commitPc,
//          mretValid, irqLevel, CSR views (mieReg, mstatus, mtvec, mepcCsr),
//          currentMode, pipeEmpty.
// Outputs: one-hot trapTrigger, trapReturn, mepc/mcause/mtval write strobes
//          and data, flushReq, redirectValid/redirectPc, registered mipOut.
// All outputs are registered; each is computed from the state being entered,
// so it is visible for exactly the cycles the FSM spends in that state.
module trap_controller
    import trap_pkg::*;
#(
    parameter int N         = 64,
    parameter int DRAIN_MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         excValid,
    input  logic [3:0]   excCode,
    input  logic [N-1:0] excPc,
    input  logic [N-1:0] excTval,
    input  logic [N-1:0] commitPc,
    input  logic         mretValid,
    input  logic [15:0]  irqLevel,
    input  logic [15:0]  mieReg,
    input  logic [N-1:0] mstatus,
    input  logic [1:0]   currentMode,
    input  logic [N-1:0] mtvec,
    input  logic [N-1:0] mepcCsr,
    input  logic         pipeEmpty,
    output logic [15:0]  trapTrigger,
    output logic         trapReturn,
    output logic         mepcWe,
    output logic         mcauseWe,
    output logic         mtvalWe,
    output logic [N-1:0] mepcOut,
    output logic [N-1:0] mcauseOut,
    output logic [N-1:0] mtvalOut,
    output logic         flushReq,
    output logic         redirectValid,
    output logic [N-1:0] redirectPc,
    output logic [15:0]  mipOut
);

    localparam int WDW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

    trap_state_t    state_q, state_d;
    logic [3:0]     cause_q, cause_d;
    logic [N-1:0]   pc_q, pc_d;
    logic [N-1:0]   tval_q, tval_d;
    logic           isirq_q, isirq_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic           irq_valid;
    logic [3:0]     irq_cause;
    logic           irq_take;
    logic [N-1:0]   vec_pc;

    // Only MIE is consumed from mstatus.
    logic unused_mstatus;
    assign unused_mstatus = ^{mstatus[N-1:MSTATUS_MIE+1], mstatus[MSTATUS_MIE-1:0]};

    irq_priority_encoder u_prio (
        .mask_i  (mipOut & mieReg),
        .valid_o (irq_valid),
        .cause_o (irq_cause)
    );

    // Machine-mode code is only interruptible with MIE set.
    assign irq_take = irq_valid && ((currentMode != 2'b11) || mstatus[MSTATUS_MIE]);

    // Vectored offset only for interrupts in mode 1; modes 2/3 fall back to direct.
    assign vec_pc = {mtvec[N-1:2], 2'b00}
                  + (((mtvec[1:0] == 2'b01) && isirq_q) ? {{(N-6){1'b0}}, cause_q, 2'b00} : '0);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        isirq_d = isirq_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                if (excValid) begin
                    // Commit has already squashed the faulting op: no drain needed.
                    cause_d = excCode;
                    pc_d    = excPc;
                    tval_d  = excTval;
                    isirq_d = 1'b0;
                    state_d = ENTER;
                end else if (mretValid) begin
                    state_d = RET;
                end else if (irq_take) begin
                    cause_d = irq_cause;
                    pc_d    = commitPc;
                    tval_d  = '0;
                    isirq_d = 1'b1;
                    wd_d    = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (excValid) begin
                    // A late exception displaces the pending interrupt.
                    cause_d = excCode;
                    pc_d    = excPc;
                    tval_d  = excTval;
                    isirq_d = 1'b0;
                    state_d = ENTER;
                end else if (pipeEmpty || (wd_q == WDW'(DRAIN_MAX - 1))) begin
                    state_d = ENTER;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ENTER:    state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            RET:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cause_q       <= '0;
            pc_q          <= '0;
            tval_q        <= '0;
            isirq_q       <= 1'b0;
            wd_q          <= '0;
            mipOut        <= '0;
            trapTrigger   <= '0;
            trapReturn    <= 1'b0;
            mepcWe        <= 1'b0;
            mcauseWe      <= 1'b0;
            mtvalWe       <= 1'b0;
            mepcOut       <= '0;
            mcauseOut     <= '0;
            mtvalOut      <= '0;
            flushReq      <= 1'b0;
            redirectValid <= 1'b0;
            redirectPc    <= '0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            pc_q          <= pc_d;
            tval_q        <= tval_d;
            isirq_q       <= isirq_d;
            wd_q          <= wd_d;
            mipOut        <= irqLevel;
            trapTrigger   <= '0;
            trapReturn    <= 1'b0;
            mepcWe        <= 1'b0;
            mcauseWe      <= 1'b0;
            mtvalWe       <= 1'b0;
            mepcOut       <= '0;
            mcauseOut     <= '0;
            mtvalOut      <= '0;
            flushReq      <= 1'b0;
            redirectValid <= 1'b0;
            redirectPc    <= '0;
            unique case (state_d)
                DRAIN: flushReq <= 1'b1;
                ENTER: begin
                    trapTrigger <= 16'b1 << cause_d;
                    mepcWe      <= 1'b1;
                    mcauseWe    <= 1'b1;
                    mtvalWe     <= 1'b1;
                    mepcOut     <= {pc_d[N-1:2], 2'b00};
                    mcauseOut   <= {isirq_d, {(N-5){1'b0}}, cause_d};
                    mtvalOut    <= isirq_d ? '0 : tval_d;
                    flushReq    <= 1'b1;
                end
                REDIRECT: begin
                    redirectValid <= 1'b1;
                    redirectPc    <= vec_pc;
                end
                RET: begin
                    trapReturn    <= 1'b1;
                    redirectValid <= 1'b1;
                    redirectPc    <= mepcCsr;
                    flushReq      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
